// File: rtl/lsu_mem_seq_pkg.sv
// Shared types for the load/store unit: operation codes, FSM states and
// size decode helpers used by both the control path and the lane aligner.
package lsu_mem_seq_pkg;

  typedef enum logic [2:0] {
    LSU_LW  = 3'd0,
    LSU_LH  = 3'd1,
    LSU_LHU = 3'd2,
    LSU_LB  = 3'd3,
    LSU_LBU = 3'd4,
    LSU_SW  = 3'd5,
    LSU_SH  = 3'd6,
    LSU_SB  = 3'd7
  } lsu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  function automatic logic [2:0] op_size(input lsu_op_e op);
    case (op)
      LSU_LW, LSU_SW:          op_size = 3'd4;
      LSU_LH, LSU_LHU, LSU_SH: op_size = 3'd2;
      LSU_LB, LSU_LBU, LSU_SB: op_size = 3'd1;
      default:                 op_size = 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] size_mask(input lsu_op_e op);
    case (op_size(op))
      3'd4:    size_mask = 4'b1111;
      3'd2:    size_mask = 4'b0011;
      3'd1:    size_mask = 4'b0001;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic is_store(input lsu_op_e op);
    case (op)
      LSU_SW, LSU_SH, LSU_SB: is_store = 1'b1;
      default:                is_store = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_seq_align.sv
// Lane aligner: byte enables and shifted store data per beat, plus merge of
// up to two read words and sign/zero extension of load results.
module lsu_mem_seq_align
  import lsu_mem_seq_pkg::*;
(
  input  lsu_op_e     op,
  input  logic [1:0]  off,
  input  logic        beat,
  input  logic [31:0] wdata,
  input  logic [31:0] w0,
  input  logic [31:0] w1,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic [31:0] load_data
);

  logic [2:0]  back_sh_s;
  logic [5:0]  lo_sh_s;
  logic [5:0]  hi_sh_s;
  logic [31:0] word_s;

  assign lo_sh_s   = {1'b0, off, 3'b000};
  assign hi_sh_s   = 6'd32 - lo_sh_s;
  assign back_sh_s = 3'd4 - {1'b0, off};

  // Store side: beat 1 carries the bytes that spilled past the base word.
  always_comb begin
    if (beat) begin
      be         = size_mask(op) >> back_sh_s;
      lane_wdata = wdata >> hi_sh_s;
    end else begin
      be         = size_mask(op) << off;
      lane_wdata = wdata << lo_sh_s;
    end
  end

  // Load side: {w1,w0} shifted down by the offset yields the right-justified value.
  always_comb begin
    word_s = 32'({w1, w0} >> lo_sh_s);
    case (op)
      LSU_LW:  load_data = word_s;
      LSU_LH:  load_data = {{16{word_s[15]}}, word_s[15:0]};
      LSU_LHU: load_data = {16'h0000, word_s[15:0]};
      LSU_LB:  load_data = {{24{word_s[7]}}, word_s[7:0]};
      LSU_LBU: load_data = {24'h00_0000, word_s[7:0]};
      default: load_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/lsu_mem_seq.sv
// Sequential load/store unit: one request at a time, one or two memory beats
// per request, every beat bounded by a timeout that yields an error response.
module lsu_mem_seq
  import lsu_mem_seq_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int ALLOW_MISALIGN = 1,
  parameter int TIMEOUT_CYC    = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam int               CNT_W       = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(TIMEOUT_CYC);
  localparam logic             ALLOW_SPLIT = (ALLOW_MISALIGN != 0);
  localparam logic             TO_EN       = (TIMEOUT_CYC != 0);

  lsu_state_e        state_r, state_next_s;
  lsu_op_e           op_r, cur_op_s;
  logic [ADDR_W-1:0] addr_r, cur_addr_s, base_addr_s;
  logic [31:0]       wdata_r, cur_wdata_s, rdata0_r, w0_s;
  logic              cross_r, req_cross_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              accept_s, ack_s, wait_s, timeout_s;
  logic              beat1_next_s, in_beat_next_s;
  logic [3:0]        be_s;
  logic [31:0]       lane_wdata_s, load_data_s, load_result_s;
  logic              resp_err_next_s;
  logic [31:0]       resp_data_next_s;
  logic              mem_req_r, mem_we_r, resp_valid_r, resp_err_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [3:0]        mem_be_r;
  logic [31:0]       mem_wdata_r, resp_rdata_r;

  if (ADDR_W < 32) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_W];
  end

  assign req_ready = (state_r == ST_IDLE) && !rst;
  assign accept_s  = req_valid && req_ready;
  assign ack_s     = mem_req_r && mem_ack;
  assign wait_s    = mem_req_r && !mem_ack;
  assign timeout_s = TO_EN && wait_s && (cnt_r == CNT_MAX);

  // In IDLE the outgoing beat is computed straight from the incoming request.
  always_comb begin
    if (state_r == ST_IDLE) begin
      cur_op_s    = lsu_op_e'(req_op);
      cur_addr_s  = req_addr[ADDR_W-1:0];
      cur_wdata_s = req_wdata;
    end else begin
      cur_op_s    = op_r;
      cur_addr_s  = addr_r;
      cur_wdata_s = wdata_r;
    end
  end

  assign base_addr_s    = {cur_addr_s[ADDR_W-1:2], 2'b00};
  assign req_cross_s    = ({1'b0, req_addr[1:0]} + op_size(lsu_op_e'(req_op))) > 3'd4;
  assign beat1_next_s   = (state_next_s == ST_BEAT1);
  assign in_beat_next_s = (state_next_s == ST_BEAT0) || beat1_next_s;
  assign w0_s           = (state_r == ST_BEAT1) ? rdata0_r : mem_rdata;
  assign load_result_s  = is_store(op_r) ? 32'h0000_0000 : load_data_s;

  lsu_mem_seq_align u_align (
    .op         (cur_op_s),
    .off        (cur_addr_s[1:0]),
    .beat       (beat1_next_s),
    .wdata      (cur_wdata_s),
    .w0         (w0_s),
    .w1         (mem_rdata),
    .be         (be_s),
    .lane_wdata (lane_wdata_s),
    .load_data  (load_data_s)
  );

  // Next-state and response-value selection.
  always_comb begin
    state_next_s     = state_r;
    resp_err_next_s  = 1'b0;
    resp_data_next_s = 32'h0000_0000;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && req_cross_s && !ALLOW_SPLIT) begin
          state_next_s    = ST_RESP;
          resp_err_next_s = 1'b1;
        end else if (accept_s) begin
          state_next_s = ST_BEAT0;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_BEAT0: begin
        if (ack_s && cross_r) begin
          state_next_s = ST_BEAT1;
        end else if (ack_s) begin
          state_next_s     = ST_RESP;
          resp_data_next_s = load_result_s;
        end else if (timeout_s) begin
          state_next_s    = ST_RESP;
          resp_err_next_s = 1'b1;
        end else begin
          state_next_s = ST_BEAT0;
        end
      end
      ST_BEAT1: begin
        if (ack_s) begin
          state_next_s     = ST_RESP;
          resp_data_next_s = load_result_s;
        end else if (timeout_s) begin
          state_next_s    = ST_RESP;
          resp_err_next_s = 1'b1;
        end else begin
          state_next_s = ST_BEAT1;
        end
      end
      ST_RESP: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_next_s;
  end

  // Request latch and first read word of a split load.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r     <= LSU_LW;
      addr_r   <= {ADDR_W{1'b0}};
      wdata_r  <= 32'h0000_0000;
      cross_r  <= 1'b0;
      rdata0_r <= 32'h0000_0000;
    end else begin
      if (accept_s) begin
        op_r    <= lsu_op_e'(req_op);
        addr_r  <= req_addr[ADDR_W-1:0];
        wdata_r <= req_wdata;
        cross_r <= req_cross_s;
      end
      if ((state_r == ST_BEAT0) && ack_s) rdata0_r <= mem_rdata;
    end
  end

  // Wait counter restarts whenever a new beat is launched.
  always_ff @(posedge clk) begin
    if (rst)                                              cnt_r <= {CNT_W{1'b0}};
    else if (in_beat_next_s && (state_next_s != state_r)) cnt_r <= {CNT_W{1'b0}};
    else if (TO_EN && wait_s)                             cnt_r <= cnt_r + CNT_W'(1);
    else                                                  cnt_r <= cnt_r;
  end

  // Registered memory port; beat 1 targets the following word, wrapping in ADDR_W.
  always_ff @(posedge clk) begin
    if (rst || !in_beat_next_s) begin
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_be_r    <= 4'b0000;
      mem_wdata_r <= 32'h0000_0000;
    end else begin
      mem_req_r   <= 1'b1;
      mem_we_r    <= is_store(cur_op_s);
      mem_addr_r  <= beat1_next_s ? (base_addr_s + ADDR_W'(4)) : base_addr_s;
      mem_be_r    <= be_s;
      mem_wdata_r <= lane_wdata_s;
    end
  end

  // Registered response; read data holds until the next response.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
    end else begin
      resp_valid_r <= (state_next_s == ST_RESP);
      resp_err_r   <= resp_err_next_s;
      if (state_next_s == ST_RESP) resp_rdata_r <= resp_data_next_s;
    end
  end

  assign mem_req    = mem_req_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_be     = mem_be_r;
  assign mem_wdata  = mem_wdata_r;
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_rdata = resp_rdata_r;

endmodule

// File: tb/tb_lsu_mem_seq.sv
// Self-checking bench for lsu_mem_seq: scoreboard of expected responses plus
// per-scenario checks of beats, latency, timeout and reset abort.
module tb_lsu_mem_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        resp_valid, resp_err, mem_req, mem_we;
  logic [31:0] resp_rdata, mem_wdata;
  logic [15:0] mem_addr;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  logic        n_req_valid = 1'b0;
  logic        n_req_ready;
  logic [2:0]  n_req_op = 3'd0;
  logic [31:0] n_req_addr = 32'h0, n_req_wdata = 32'h0;
  logic        n_resp_valid, n_resp_err, n_mem_req, n_mem_we;
  logic [31:0] n_resp_rdata, n_mem_wdata;
  logic [15:0] n_mem_addr;
  logic [3:0]  n_mem_be;
  logic        n_mem_ack = 1'b0;
  logic [31:0] n_mem_rdata = 32'h0;

  lsu_mem_seq #(.ADDR_W(16), .ALLOW_MISALIGN(1), .TIMEOUT_CYC(15)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata));

  lsu_mem_seq #(.ADDR_W(16), .ALLOW_MISALIGN(0), .TIMEOUT_CYC(15)) dut_nm (
    .clk(clk), .rst(rst), .req_valid(n_req_valid), .req_ready(n_req_ready), .req_op(n_req_op),
    .req_addr(n_req_addr), .req_wdata(n_req_wdata), .resp_valid(n_resp_valid), .resp_rdata(n_resp_rdata),
    .resp_err(n_resp_err), .mem_req(n_mem_req), .mem_we(n_mem_we), .mem_addr(n_mem_addr), .mem_be(n_mem_be),
    .mem_wdata(n_mem_wdata), .mem_ack(n_mem_ack), .mem_rdata(n_mem_rdata));

  typedef struct packed { logic [31:0] rdata; logic err; } exp_t;
  exp_t sb[$];
  int total = 0;
  int bad = 0;

  // Present one request on the main DUT; returns at the negedge after acceptance.
  task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Capture the pending beat, then ack it after wait_cyc idle cycles.
  task automatic serve_beat(input int wait_cyc, input logic [31:0] rd, output bit seen,
                            output logic [15:0] a, output logic [3:0] be, output logic [31:0] wd,
                            output logic we);
    int n = 0;
    while (!mem_req && n < 50) begin @(negedge clk); n++; end
    seen = mem_req; a = mem_addr; be = mem_be; wd = mem_wdata; we = mem_we;
    repeat (wait_cyc) @(negedge clk);
    mem_ack = 1'b1; mem_rdata = rd;
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  // Wait for resp_valid; lat counts extra negedges waited.
  task automatic wait_resp(output bit seen, output int lat, output logic [31:0] rd, output logic er);
    lat = 0;
    while (!resp_valid && lat < 50) begin @(negedge clk); lat++; end
    seen = resp_valid; rd = resp_rdata; er = resp_err;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({req_ready, resp_valid, resp_err, mem_req, mem_we} !== 5'b0) begin
      bad++; $display("FAIL reset_ctl: got %b want 00000", {req_ready, resp_valid, resp_err, mem_req, mem_we});
    end
    total++;
    if ({mem_addr, mem_be, mem_wdata, resp_rdata} !== 84'h0) begin
      bad++; $display("FAIL reset_data: got addr=%h be=%b wd=%h rd=%h want 0", mem_addr, mem_be, mem_wdata, resp_rdata);
    end
    rst = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_loads();
    logic [31:0] pat [2] = '{32'h8080_8080, 32'h7F7F_7F7F};
    logic [31:0] want [2][5] = '{'{32'h8080_8080, 32'hFFFF_8080, 32'h0000_8080, 32'hFFFF_FF80, 32'h0000_0080},
                                 '{32'h7F7F_7F7F, 32'h0000_7F7F, 32'h0000_7F7F, 32'h0000_007F, 32'h0000_007F}};
    exp_t e; bit seen; int lat; logic [31:0] rd, wd; logic er, we; logic [15:0] a; logic [3:0] be;
    for (int p = 0; p < 2; p++) begin
      for (int op = 0; op < 5; op++) begin
        e.rdata = want[p][op]; e.err = 1'b0; sb.push_back(e);
        do_req(3'(op), 32'h0, 32'h0);
        serve_beat(0, pat[p], seen, a, be, wd, we);
        total++;
        if (seen !== 1'b1 || a !== 16'h0000 || we !== 1'b0) begin
          bad++; $display("FAIL load_beat p%0d op%0d: got seen=%b addr=%h we=%b want 1 0000 0", p, op, seen, a, we);
        end
        wait_resp(seen, lat, rd, er);
        e = sb.pop_front();
        total++;
        if (seen !== 1'b1 || rd !== e.rdata || er !== e.err) begin
          bad++; $display("FAIL load_data p%0d op%0d: got v=%b rd=%h err=%b want rd=%h err=%b", p, op, seen, rd, er, e.rdata, e.err);
        end
      end
    end
  endtask

  task automatic test_stores();
    logic [2:0]  ops [3]   = '{3'd7, 3'd6, 3'd5};
    logic [31:0] addrs [3] = '{32'h3, 32'h2, 32'h0};
    logic [3:0]  bes [3]   = '{4'b1000, 4'b1100, 4'b1111};
    logic [31:0] wds [3]   = '{32'hAA00_0000, 32'hAAAA_0000, 32'hAAAA_AAAA};
    exp_t e; bit seen; int lat; logic [31:0] rd, wd; logic er, we; logic [15:0] a; logic [3:0] be;
    for (int i = 0; i < 3; i++) begin
      e.rdata = 32'h0; e.err = 1'b0; sb.push_back(e);
      do_req(ops[i], addrs[i], 32'hAAAA_AAAA);
      serve_beat(0, 32'hDEAD_BEEF, seen, a, be, wd, we);
      total++;
      if (seen !== 1'b1 || a !== 16'h0000 || be !== bes[i] || wd !== wds[i] || we !== 1'b1) begin
        bad++; $display("FAIL store_beat %0d: got addr=%h be=%b wd=%h we=%b want 0000 %b %h 1", i, a, be, wd, we, bes[i], wds[i]);
      end
      wait_resp(seen, lat, rd, er);
      e = sb.pop_front();
      total++;
      if (seen !== 1'b1 || lat !== 0 || rd !== e.rdata || er !== e.err) begin
        bad++; $display("FAIL store_resp %0d: got v=%b lat=%0d rd=%h err=%b want lat=0 rd=%h err=%b", i, seen, lat, rd, er, e.rdata, e.err);
      end
      total++;
      if (resp_valid !== 1'b0) begin bad++; $display("FAIL store_pulse %0d: got resp_valid=%b want 0", i, resp_valid); end
    end
  endtask

  task automatic test_misalign();
    exp_t e; bit s0, s1, seen; int lat; logic [31:0] rd, wd0, wd1; logic er, we0, we1;
    logic [15:0] a0, a1; logic [3:0] be0, be1; int n, reqs, resps, first; logic nerr;
    e.rdata = 32'h7788_1122; e.err = 1'b0; sb.push_back(e);
    do_req(3'd0, 32'h2, 32'h0);
    serve_beat(0, 32'h1122_3344, s0, a0, be0, wd0, we0);
    serve_beat(0, 32'h5566_7788, s1, a1, be1, wd1, we1);
    total++;
    if (s0 !== 1'b1 || s1 !== 1'b1 || a0 !== 16'h0000 || a1 !== 16'h0004 || be0 !== 4'b1100 || be1 !== 4'b0011) begin
      bad++; $display("FAIL split_beats: got a0=%h be0=%b a1=%h be1=%b want 0000 1100 0004 0011", a0, be0, a1, be1);
    end
    wait_resp(seen, lat, rd, er);
    e = sb.pop_front();
    total++;
    if (seen !== 1'b1 || lat !== 0 || rd !== e.rdata || er !== e.err) begin
      bad++; $display("FAIL split_resp: got v=%b lat=%0d rd=%h err=%b want rd=%h err=%b", seen, lat, rd, er, e.rdata, e.err);
    end
    n = 0;
    @(negedge clk);
    while (!n_req_ready && n < 50) begin @(negedge clk); n++; end
    n_req_valid = 1'b1; n_req_op = 3'd1; n_req_addr = 32'h3;
    @(negedge clk);
    n_req_valid = 1'b0;
    reqs = 0; resps = 0; first = -1; nerr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (n_mem_req) reqs++;
      if (n_resp_valid) begin
        resps++; nerr = n_resp_err;
        if (first < 0) first = i;
      end
      @(negedge clk);
    end
    total++;
    if (reqs !== 0 || resps !== 1 || nerr !== 1'b1 || first !== 0) begin
      bad++; $display("FAIL reject: got mem_req_cycles=%0d resps=%0d err=%b at=%0d want 0 1 1 0", reqs, resps, nerr, first);
    end
  endtask

  task automatic test_wrap();
    exp_t e; bit s0, s1, seen; int lat; logic [31:0] rd, wd0, wd1; logic er, we0, we1;
    logic [15:0] a0, a1; logic [3:0] be0, be1;
    e.rdata = 32'h0; e.err = 1'b0; sb.push_back(e);
    do_req(3'd5, 32'h0000_FFFD, 32'h1122_3344);
    serve_beat(0, 32'h0, s0, a0, be0, wd0, we0);
    serve_beat(0, 32'h0, s1, a1, be1, wd1, we1);
    total++;
    if (a0 !== 16'hFFFC || be0 !== 4'b1110 || wd0 !== 32'h2233_4400 || we0 !== 1'b1) begin
      bad++; $display("FAIL wrap_beat0: got a=%h be=%b wd=%h we=%b want fffc 1110 22334400 1", a0, be0, wd0, we0);
    end
    total++;
    if (s1 !== 1'b1 || a1 !== 16'h0000 || be1 !== 4'b0001 || wd1 !== 32'h0000_0011) begin
      bad++; $display("FAIL wrap_beat1: got a=%h be=%b wd=%h want 0000 0001 00000011", a1, be1, wd1);
    end
    wait_resp(seen, lat, rd, er);
    e = sb.pop_front();
    total++;
    if (seen !== 1'b1 || rd !== e.rdata || er !== e.err) begin
      bad++; $display("FAIL wrap_resp: got v=%b rd=%h err=%b want rd=%h err=%b", seen, rd, er, e.rdata, e.err);
    end
  endtask

  task automatic test_timeout();
    exp_t e; bit s0, seen; int lat, n; logic [31:0] rd, wd0; logic er, we0; logic [15:0] a0; logic [3:0] be0;
    e.rdata = 32'h0; e.err = 1'b1; sb.push_back(e);
    do_req(3'd0, 32'h10, 32'h0);
    n = 0;
    while (mem_req && n < 40) begin n++; @(negedge clk); end
    total++;
    if (n !== 16) begin bad++; $display("FAIL timeout_len: got mem_req cycles=%0d want 16", n); end
    wait_resp(seen, lat, rd, er);
    e = sb.pop_front();
    total++;
    if (seen !== 1'b1 || lat !== 0 || rd !== e.rdata || er !== e.err) begin
      bad++; $display("FAIL timeout_resp: got v=%b lat=%0d rd=%h err=%b want rd=%h err=%b", seen, lat, rd, er, e.rdata, e.err);
    end
    e.rdata = 32'h1234_5678; e.err = 1'b0; sb.push_back(e);
    do_req(3'd0, 32'h10, 32'h0);
    serve_beat(15, 32'h1234_5678, s0, a0, be0, wd0, we0);
    wait_resp(seen, lat, rd, er);
    e = sb.pop_front();
    total++;
    if (s0 !== 1'b1 || seen !== 1'b1 || lat !== 0 || rd !== e.rdata || er !== e.err) begin
      bad++; $display("FAIL late_ack: got v=%b lat=%0d rd=%h err=%b want rd=%h err=%b", seen, lat, rd, er, e.rdata, e.err);
    end
  endtask

  task automatic test_reset_abort();
    bit s0; logic [31:0] wd0; logic we0; logic [15:0] a0; logic [3:0] be0; int resps;
    do_req(3'd0, 32'h2, 32'h0);
    serve_beat(0, 32'h0BAD_F00D, s0, a0, be0, wd0, we0);
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0004) begin
      bad++; $display("FAIL abort_beat1: got mem_req=%b addr=%h want 1 0004", mem_req, mem_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (mem_req !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      bad++; $display("FAIL abort_rst: got mem_req=%b resp_valid=%b ready=%b want 0 0 0", mem_req, resp_valid, req_ready);
    end
    rst = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b want 1", req_ready); end
    resps = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (resp_valid || mem_req) resps++;
    end
    total++;
    if (resps !== 0) begin bad++; $display("FAIL abort_quiet: got %0d active cycles want 0", resps); end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_misalign();
    test_wrap();
    test_timeout();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
